// File: rtl/delay_test_sequencer.sv
// Purpose: UART-commanded PRBS7 delay-line tester; drives pattern, compares latency-aligned echo, reports 16-bit error count.
// Latency: first driven bit one cycle after the length byte; report byte valid LAT+1 cycles after the last driven bit.
// Backpressure: tx_data/tx_valid are registered and held until tx_ready; rx bytes outside IDLE/LEN_* are dropped.
module delay_test_sequencer #(
    parameter int         LAT      = 8,
    parameter logic [7:0] CMD_RUN  = 8'h52,
    parameter logic [7:0] CMD_STAT = 8'h53
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic       in,
    output logic       out,
    output logic       out_en,
    output logic       busy
);

    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        RUN,
        DRAIN,
        REP_HI,
        REP_LO
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      len_q, len_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [6:0]       lfsr_q, lfsr_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [LAT-1:0]   exp_pipe_q, exp_pipe_d;
    logic [LAT-1:0]   vld_pipe_q, vld_pipe_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             busy_q, busy_d;
    logic             new_exp;
    logic             new_vld;

    // Line drive is decoded straight from the state register so that reset
    // removes the drive enable asynchronously, without waiting for a clock.
    assign out_en   = (state_q == RUN);
    assign out      = (state_q == RUN) ? lfsr_q[6] : 1'b0;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;

    // Sequencer: command decode, PRBS generation, echo compare and report staging.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        lfsr_d     = lfsr_q;
        err_cnt_d  = err_cnt_q;
        drain_d    = drain_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        new_exp    = 1'b0;
        new_vld    = 1'b0;

        // Compare the echo against the bit driven LAT cycles ago; saturate.
        if ((state_q == RUN || state_q == DRAIN) && vld_pipe_q[LAT-1] &&
            (in != exp_pipe_q[LAT-1]) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_RUN) begin
                        state_d = LEN_HI;
                    end else if (rx_data == CMD_STAT) begin
                        state_d    = REP_HI;
                        tx_valid_d = 1'b1;
                        tx_data_d  = err_cnt_q[15:8];
                    end
                end
            end
            LEN_HI: begin
                if (rx_valid) begin
                    len_d[15:8] = rx_data;
                    state_d     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (rx_valid) begin
                    len_d[7:0] = rx_data;
                    err_cnt_d  = 16'd0;
                    lfsr_d     = 7'h7F;
                    cnt_d      = len_d;
                    if (len_d == 16'd0) begin
                        // Nothing to drive: report the freshly cleared count.
                        state_d    = REP_HI;
                        tx_valid_d = 1'b1;
                        tx_data_d  = 8'h00;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                new_exp = lfsr_q[6];
                new_vld = 1'b1;
                lfsr_d  = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
                cnt_d   = cnt_q - 16'd1;
                if (cnt_q == 16'd1) begin
                    state_d = DRAIN;
                    drain_d = DW'(LAT - 1);
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    // Last compare lands this cycle, so stage err_cnt_d.
                    state_d    = REP_HI;
                    tx_valid_d = 1'b1;
                    tx_data_d  = err_cnt_d[15:8];
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            REP_HI: begin
                if (tx_ready) begin
                    state_d   = REP_LO;
                    tx_data_d = err_cnt_q[7:0];
                end
            end
            REP_LO: begin
                if (tx_ready) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Expected-bit / valid-tag delay line; zeros shift in whenever not driving.
    always_comb begin
        exp_pipe_d = exp_pipe_q;
        vld_pipe_d = vld_pipe_q;
        for (int i = LAT - 1; i > 0; i--) begin
            exp_pipe_d[i] = exp_pipe_q[i-1];
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end
        exp_pipe_d[0] = new_exp;
        vld_pipe_d[0] = new_vld;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= 16'd0;
            cnt_q      <= 16'd0;
            lfsr_q     <= 7'h7F;
            err_cnt_q  <= 16'd0;
            drain_q    <= '0;
            exp_pipe_q <= '0;
            vld_pipe_q <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            lfsr_q     <= lfsr_d;
            err_cnt_q  <= err_cnt_d;
            drain_q    <= drain_d;
            exp_pipe_q <= exp_pipe_d;
            vld_pipe_q <= vld_pipe_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: doc/delay_test_sequencer.md
Name: delay_test_sequencer

Overview:
- Command-driven test controller for the delay-line test harness. Sits between the UART byte interface and the line driver/receiver.
- Receives a run command over UART, then drives a PRBS7 pattern onto the line through the tristate enable. It compares the returned signal against a latency-aligned reference and reports a 16-bit error count back over UART.
- Sequences the whole drive / drain / report cycle so that the host only ever sends a command and reads two bytes.

Parameters:
- LAT, 8: line round-trip latency in clk cycles. A bit driven in cycle t is compared with `in` in cycle t+LAT. Legal range 1..64.
- CMD_RUN, 8'h52: command byte that starts a run.
- CMD_STAT, 8'h53: command byte that re-reports the last error count.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  asynchronous, active-high reset.
- rx_data  input  8  received UART byte.
- rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
- tx_data  output  8  byte to transmit.
- tx_valid  output  1  tx_data valid; held until accepted.
- tx_ready  input  1  UART transmitter can accept a byte.
- in  input  1  returned line signal, already synchronised to clk.
- out  output  1  line drive data.
- out_en  output  1  line drive enable (tristate control at top level).
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: state=IDLE, out=0, out_en=0, tx_valid=0, tx_data=0, busy=0, err_cnt=0, len=0, lfsr=7'h7F, expected/valid pipelines cleared. Reset mid-run aborts immediately; out_en drops asynchronously.
- States: IDLE, LEN_HI, LEN_LO, RUN, DRAIN, REP_HI, REP_LO.
- IDLE:
  - rx_valid with CMD_RUN goes to LEN_HI.
  - rx_valid with CMD_STAT goes to REP_HI without touching err_cnt.
  - Any other byte is ignored.
- LEN_HI: the next rx_valid byte goes to len[15:8], then LEN_LO.
- LEN_LO: the next rx_valid byte goes to len[7:0]. In that same cycle err_cnt clears and lfsr loads 7'h7F.
  - If {hi,lo}==0, go to REP_HI (reports 0).
  - Otherwise go to RUN with remaining count = len.
- RUN, one bit per cycle:
  - out_en=1, out=lfsr[6].
  - lfsr shifts left, inserting lfsr[6]^lfsr[5] (x^7+x^6+1).
  - The expected bit and a valid tag enter a LAT-deep shift pipeline.
  - Remaining count decrements. After the cycle that drives bit N, go to DRAIN.
- DRAIN: out_en=0, out=0. Stays exactly LAT cycles, with the pipeline shifting zeros and valid=0. Then go to REP_HI.
- Compare:
  - Runs every cycle in RUN and DRAIN.
  - When the pipeline output tag is valid and in != expected, err_cnt increments.
  - err_cnt saturates at 16'hFFFF.
  - Exactly N comparisons are made per run.
- REP_HI: tx_valid=1, tx_data=err_cnt[15:8]. On tx_valid&&tx_ready go to REP_LO.
- REP_LO: tx_data=err_cnt[7:0]. On handshake, tx_valid drops next cycle and the state returns to IDLE.
- tx_data and tx_valid are registered and must not change while tx_valid=1 and tx_ready=0.
- rx_valid bytes received in RUN, DRAIN, REP_HI or REP_LO are discarded. No queueing.
- Latency:
  - Command accept to first driven bit: 1 cycle, i.e. out_en rises the cycle after the LEN_LO byte.
  - Last driven bit to tx_valid: LAT+1 cycles.
- busy is registered and equals (state != IDLE).
- len=16'hFFFF is legal and gives 65535 RUN cycles.

Test Plan:
- Loopback, LAT=8: drive `in` with out delayed 8 cycles. Send 52 00 10 → out_en high for exactly 16 cycles. First 7 out bits are 1, 8th is 0. Report bytes 00 00.
- Inverted loopback: in = ~out delayed 8 cycles. Send 52 01 00 → report 01 00 (256 errors).
- Zero length: send 52 00 00 → out_en never rises. tx bytes 00 00 appear within 3 cycles.
- Status and backpressure:
  - After the inverted run, hold tx_ready=0 for 20 cycles then send 53. tx_valid holds with tx_data=01 stable.
  - Release tx_ready → 01 then 00, then IDLE with busy=0.
- Junk and overlap:
  - Send 41, then 52 00 04. During RUN inject rx byte 52. Run completes with 4 bits and exactly one report pair.
  - The injected byte is ignored, with no second run.
- Reset mid-run: send 52 00 40 and assert reset at RUN cycle 10 → out_en=0 immediately, no tx bytes, busy=0. A following 53 reports 00 00.
